// File: rtl/mdu_pkg.sv
// Shared encodings and timing defaults for the HI/LO multiply/divide unit.
// The decode/stall logic imports this package, so keep it free of datapath detail.
`timescale 1ns/1ps
package mdu_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_RSV6  = 3'd6,
        MD_RSV7  = 3'd7
    } mdop_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Ops 0-3 occupy the unit for a multi-cycle busy period; 4-7 never do.
    function automatic logic is_long_op(input logic [2:0] op);
        return ~op[2];
    endfunction

    // Within the long ops, bit 1 separates divide from multiply.
    function automatic logic is_div_op(input logic [2:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: result computed in one cycle into shadow registers,
// then held back for a fixed busy period before being committed to HI/LO.
`timescale 1ns/1ps
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e        state_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [31:0]       shadow_hi_reg;
    logic [31:0]       shadow_lo_reg;
    logic              shadow_commit_reg;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               signed_div;
    logic               neg_a;
    logic               neg_b;
    logic               divisor_zero;
    logic [31:0]        mag_a;
    logic [31:0]        mag_b;
    logic [31:0]        mag_q;
    logic [31:0]        mag_r;
    logic [31:0]        quot;
    logic [31:0]        rem;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;
    logic               res_commit;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide runs on magnitudes; 0x80000000 / -1 then wraps to 0x80000000 naturally.
    assign signed_div   = (mdop == MD_DIV);
    assign neg_a        = signed_div & A[31];
    assign neg_b        = signed_div & B[31];
    assign divisor_zero = (B == 32'd0);
    assign mag_a        = neg_a ? (~A + 32'd1) : A;
    assign mag_b        = neg_b ? (~B + 32'd1) : B;
    assign mag_q        = divisor_zero ? 32'd0 : (mag_a / mag_b);
    assign mag_r        = divisor_zero ? 32'd0 : (mag_a % mag_b);
    assign quot         = (neg_a ^ neg_b) ? (~mag_q + 32'd1) : mag_q;
    assign rem          = neg_a ? (~mag_r + 32'd1) : mag_r;

    always_comb begin
        res_hi     = 32'd0;
        res_lo     = 32'd0;
        res_commit = 1'b1;
        case (mdop_e'(mdop))
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV, MD_DIVU: begin
                res_hi     = rem;
                res_lo     = quot;
                res_commit = ~divisor_zero;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= ST_IDLE;
            busy              <= 1'b0;
            HI                <= 32'd0;
            LO                <= 32'd0;
            count_reg         <= '0;
            shadow_hi_reg     <= 32'd0;
            shadow_lo_reg     <= 32'd0;
            shadow_commit_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (is_long_op(mdop)) begin
                            shadow_hi_reg     <= res_hi;
                            shadow_lo_reg     <= res_lo;
                            shadow_commit_reg <= res_commit;
                            count_reg         <= is_div_op(mdop) ? CNT_W'(DIV_CYCLES)
                                                                 : CNT_W'(MULT_CYCLES);
                            state_reg         <= ST_BUSY;
                            busy              <= 1'b1;
                        end else if (mdop == MD_MTHI) begin
                            HI <= A;
                        end else if (mdop == MD_MTLO) begin
                            LO <= A;
                        end
                    end
                end
                ST_BUSY: begin
                    // Final busy cycle: commit and drop busy on the same edge.
                    if (count_reg <= CNT_W'(1)) begin
                        count_reg <= '0;
                        state_reg <= ST_IDLE;
                        busy      <= 1'b0;
                        if (shadow_commit_reg) begin
                            HI <= shadow_hi_reg;
                            LO <= shadow_lo_reg;
                        end
                    end else begin
                        count_reg <= count_reg - CNT_W'(1);
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: a scoreboard of expected HI/LO and busy
// lengths is filled as operations are issued and drained as each one completes.
`timescale 1ns/1ps
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mdop  (mdop),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    // Reference model: computes the architectural result with 64-bit arithmetic.
    task automatic push_expect(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      p;
        logic [63:0] pu;
        e.hi     = m_hi;
        e.lo     = m_lo;
        e.cycles = (op >= 3'd2) ? 10 : 5;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
            3'd1: begin pu = {32'd0, a} * {32'd0, b}; e.hi = pu[63:32]; e.lo = pu[31:0]; end
            3'd2: if (b != 32'd0) begin e.lo = 32'(sa / sb); e.hi = 32'(sa % sb); end
            3'd3: if (b != 32'd0) begin e.lo = a / b; e.hi = a % b; end
            default: ;
        endcase
        m_hi = e.hi;
        m_lo = e.lo;
        sb_q.push_back(e);
    endtask

    // Called at a negedge: issue one op, then measure how long busy stays high.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output logic [31:0] hi, output logic [31:0] lo);
        start = 1'b1; mdop = op; A = a; B = b;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        hi = HI;
        lo = LO;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; mdop = 3'd0; A = 32'd0; B = 32'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b HI=%h LO=%h, required 0/0/0", busy, HI, LO);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        logic [2:0]  ops[2] = '{3'd0, 3'd1};
        logic [31:0] as[2]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF};
        logic [31:0] bs[2]  = '{32'd5, 32'd2};
        int          cyc;
        logic [31:0] hi, lo;
        exp_t        e;
        for (int i = 0; i < 2; i++) begin
            push_expect(ops[i], as[i], bs[i]);
            run_op(ops[i], as[i], bs[i], cyc, hi, lo);
            e = sb_q.pop_front();
            checks++;
            if (cyc !== e.cycles || hi !== e.hi || lo !== e.lo) begin
                errors++;
                $display("FAIL mult_%0d: busy=%0d HI=%h LO=%h, required busy=%0d HI=%h LO=%h",
                         i, cyc, hi, lo, e.cycles, e.hi, e.lo);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops[4] = '{3'd2, 3'd3, 3'd2, 3'd3};
        logic [31:0] as[4]  = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd100};
        logic [31:0] bs[4]  = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd7};
        int          cyc;
        logic [31:0] hi, lo;
        exp_t        e;
        for (int i = 0; i < 4; i++) begin
            push_expect(ops[i], as[i], bs[i]);
            run_op(ops[i], as[i], bs[i], cyc, hi, lo);
            e = sb_q.pop_front();
            checks++;
            if (cyc !== e.cycles || hi !== e.hi || lo !== e.lo) begin
                errors++;
                $display("FAIL div_%0d: busy=%0d HI=%h LO=%h, required busy=%0d HI=%h LO=%h",
                         i, cyc, hi, lo, e.cycles, e.hi, e.lo);
            end
        end
    endtask

    task automatic test_mthi_mtlo();
        start = 1'b1; mdop = 3'd4; A = 32'h1234_5678;
        @(negedge clk);
        m_hi = 32'h1234_5678;
        checks++;
        if (HI !== m_hi || LO !== m_lo || busy !== 1'b0) begin
            errors++;
            $display("FAIL mthi: HI=%h LO=%h busy=%b, required HI=%h LO=%h busy=0", HI, LO, busy, m_hi, m_lo);
        end
        mdop = 3'd5; A = 32'h9ABC_DEF0;
        @(negedge clk);
        m_lo = 32'h9ABC_DEF0;
        checks++;
        if (HI !== m_hi || LO !== m_lo || busy !== 1'b0) begin
            errors++;
            $display("FAIL mtlo: HI=%h LO=%h busy=%b, required HI=%h LO=%h busy=0", HI, LO, busy, m_hi, m_lo);
        end
        for (int op = 6; op < 8; op++) begin
            mdop = 3'(op); A = 32'hFFFF_0000; B = 32'd3;
            @(negedge clk);
            checks++;
            if (HI !== m_hi || LO !== m_lo || busy !== 1'b0) begin
                errors++;
                $display("FAIL reserved_%0d: HI=%h LO=%h busy=%b, required HI=%h LO=%h busy=0",
                         op, HI, LO, busy, m_hi, m_lo);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_busy_ignore();
        int   cyc = 0;
        exp_t e;
        push_expect(3'd0, 32'd3, 32'd7);
        start = 1'b1; mdop = 3'd0; A = 32'd3; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            if (cyc == 2) begin start = 1'b1; mdop = 3'd5; A = 32'hDEAD_BEEF; end
            else start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        e = sb_q.pop_front();
        checks++;
        if (cyc !== e.cycles || HI !== e.hi || LO !== e.lo) begin
            errors++;
            $display("FAIL busy_ignore: busy=%0d HI=%h LO=%h, required busy=%0d HI=%h LO=%h",
                     cyc, HI, LO, e.cycles, e.hi, e.lo);
        end
    endtask

    task automatic test_reset_abort();
        int   cyc = 0;
        logic stray = 1'b0;
        exp_t e;
        start = 1'b1; mdop = 3'd2; A = 32'd100; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        while (busy === 1'b1 && cyc < 4) begin
            cyc++;
            if (cyc < 4) @(negedge clk);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL async_abort: busy=%b HI=%h LO=%h, required 0/0/0", busy, HI, LO);
        end
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) stray = 1'b1;
        end
        checks++;
        if (stray !== 1'b0) begin
            errors++;
            $display("FAIL no_commit_after_abort: stray activity=%b, required 0", stray);
        end
        // First op after reset must be accepted at the very next edge.
        push_expect(3'd1, 32'hFFFF_FFFF, 32'd2);
        start = 1'b1; mdop = 3'd1; A = 32'hFFFF_FFFF; B = 32'd2;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL accept_after_reset: busy=%b, required 1", busy);
        end
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        e = sb_q.pop_front();
        checks++;
        if (cyc !== e.cycles || HI !== e.hi || LO !== e.lo) begin
            errors++;
            $display("FAIL post_reset_multu: busy=%0d HI=%h LO=%h, required busy=%0d HI=%h LO=%h",
                     cyc, HI, LO, e.cycles, e.hi, e.lo);
        end
    endtask

    task automatic test_back_to_back();
        int          cyc;
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
        exp_t        e;
        for (int i = 0; i < 8; i++) begin
            op = 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i == 5) ? 32'd0 : (op >= 3'd2 ? 32'($urandom_range(1, 40000)) : $urandom);
            if (i == 2) b = -32'sd13;
            push_expect(op, a, b);
            run_op(op, a, b, cyc, hi, lo);
            e = sb_q.pop_front();
            checks++;
            if (cyc !== e.cycles || hi !== e.hi || lo !== e.lo) begin
                errors++;
                $display("FAIL b2b_%0d op=%0d a=%h b=%h: busy=%0d HI=%h LO=%h, required busy=%0d HI=%h LO=%h",
                         i, op, a, b, cyc, hi, lo, e.cycles, e.hi, e.lo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        checks++;
        if (sb_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
